c3lib_gray_rdptr_ctrl: RTL

// Read-side pointer controller for a dual-clock FIFO. Runs in the read domain.

---
 rtl/c3lib_fifo_pkg.sv | 19 +
 rtl/c3lib_graytobin.sv | 17 +
 rtl/c3lib_gray_rdptr_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/c3lib_fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO pointer logic.
package c3lib_fifo_pkg;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } rdptr_state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] x);
        return x ^ (x >> 32'd1);
    endfunction

    // A legally synchronized gray pointer moves by at most one bit per sample.
    function automatic logic popcount1_ok(input logic [31:0] a, input logic [31:0] b);
        return ($countones(a ^ b) <= 32'sd1);
    endfunction

endpackage

// File: rtl/c3lib_graytobin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module c3lib_graytobin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Prefix-XOR from the MSB down.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/c3lib_gray_rdptr_ctrl.sv
// Read-side pointer controller for a dual-clock FIFO: pointer tracking, fill level,
// empty/almost-empty flags, valid/ready pop and gray-code corruption detection.
module c3lib_gray_rdptr_ctrl
    import c3lib_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2,
    parameter int WARMUP_CYC    = 3,
    localparam int PTR_W        = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_W-1:0]      wr_ptr_gray_sync,
    input  logic                  rd_ready,
    input  logic                  clr_err,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PTR_W-1:0]      rd_ptr_gray,
    output logic [PTR_W-1:0]      fill_level,
    output logic                  empty,
    output logic                  aempty,
    output logic                  gray_err
);

    localparam int CNT_W = (WARMUP_CYC >= 2) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYC - 1);
    localparam logic [PTR_W-1:0] DEPTH_L   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0] AEMPTY_L  = PTR_W'(AEMPTY_THRESH);

    rdptr_state_e     state_r;
    rdptr_state_e     state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] wg_r;
    logic [PTR_W-1:0] wg_prev_r;
    logic [PTR_W-1:0] wg_bin_s;
    logic [PTR_W-1:0] wr_ptr_bin_r;
    logic [PTR_W-1:0] rd_ptr_bin_r;
    logic [PTR_W-1:0] rd_ptr_gray_r;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [PTR_W-1:0] rd_gray_next_s;
    logic [PTR_W-1:0] fill_s;
    logic             gray_err_r;
    logic             armed_r;
    logic             empty_s;
    logic             rd_valid_s;
    logic             pop_s;
    logic             err_det_s;

    c3lib_graytobin #(.WIDTH(PTR_W)) u_graytobin (
        .gray (wg_r),
        .bin  (wg_bin_s)
    );

    // Fill level, handshake and corruption detection derived from registered state.
    always_comb begin
        fill_s         = wr_ptr_bin_r - rd_ptr_bin_r;
        empty_s        = (fill_s == '0);
        rd_valid_s     = (state_r == RUN) && !empty_s;
        pop_s          = rd_valid_s && rd_ready;
        rd_ptr_inc_s   = rd_ptr_bin_r + PTR_W'(1);
        rd_gray_next_s = PTR_W'(bin2gray(32'(rd_ptr_inc_s)));
        // The first RUN sample only sets the baseline for the bit-change check.
        err_det_s      = (state_r == RUN) &&
                         ((fill_s > DEPTH_L) ||
                          (armed_r && !popcount1_ok(32'(wg_r), 32'(wg_prev_r))));
    end

    // Next-state logic for the WARM/RUN/ERR controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            WARM: begin
                if (cnt_r == WARM_LAST) state_next_s = RUN;
                else                    state_next_s = WARM;
            end
            RUN: begin
                if (err_det_s) state_next_s = ERR;
                else           state_next_s = RUN;
            end
            ERR: begin
                if (clr_err) state_next_s = RUN;
                else         state_next_s = ERR;
            end
            default: state_next_s = WARM;
        endcase
    end

    // State, pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= WARM;
            cnt_r         <= '0;
            wg_r          <= '0;
            wg_prev_r     <= '0;
            wr_ptr_bin_r  <= '0;
            rd_ptr_bin_r  <= '0;
            rd_ptr_gray_r <= '0;
            gray_err_r    <= 1'b0;
            armed_r       <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            wg_r      <= wr_ptr_gray_sync;
            wg_prev_r <= wg_r;
            armed_r   <= (state_r == RUN);
            if ((state_r == WARM) && (cnt_r != WARM_LAST)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            // A corrupt sample is never loaded; the last good write pointer is kept.
            if ((state_r == RUN) && !err_det_s) begin
                wr_ptr_bin_r <= wg_bin_s;
            end
            if (pop_s) begin
                rd_ptr_bin_r  <= rd_ptr_inc_s;
                rd_ptr_gray_r <= rd_gray_next_s;
            end
            if ((state_r == RUN) && err_det_s) begin
                gray_err_r <= 1'b1;
            end else if ((state_r == ERR) && clr_err) begin
                gray_err_r <= 1'b0;
            end
        end
    end

    assign rd_valid    = rd_valid_s;
    assign rd_addr     = rd_ptr_bin_r[ADDR_WIDTH-1:0];
    assign rd_ptr_gray = rd_ptr_gray_r;
    assign fill_level  = fill_s;
    assign empty       = empty_s;
    assign aempty      = (fill_s <= AEMPTY_L);
    assign gray_err    = gray_err_r;

endmodule
